// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: FPU issue scheduler. It uses a per-op latency table, a writeback-slot
// reservation shift register and a 64-entry busy scoreboard (32 f-regs + 32 x-regs),
// so independent FP ops can overlap while they are in flight.
// Optional build macro: FPU_SCHED_PERF_EN adds the perf_issue and perf_haz_* counters.
// Op encoding: FADD 00000, FSUB 00001, FMUL 00010, FDIV 00011, FSQRT 00100,
//   FHALF 00101, FINV 00110, FFLOOR 00111, FSGNJ 01000, FSGNJN 01001, FSGNJX 01010,
//   FCOMP 10100, FTOI 11000, ITOF 11001. Fused = funct5[4]==0 && funct3!=0.
module fpu_issue_sched #(
  parameter int unsigned MAX_LAT = 11,
  parameter int unsigned NREG    = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] funct5,
  input  logic [2:0] funct3,
  input  logic [2:0] rs_v,
  input  logic [5:0] rs1_idx,
  input  logic [5:0] rs2_idx,
  input  logic [5:0] rs3_idx,
  input  logic       rd_we,
  input  logic [5:0] rd_idx,
  output logic       issue_valid,
  output logic [3:0] issue_lat,
  output logic       wb_valid,
  output logic       wb_we,
  output logic [5:0] wb_rd,
  output logic       inflight
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_haz_raw,
  output logic [31:0] perf_haz_waw,
  output logic [31:0] perf_haz_slot
`endif
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] X0_IDX = 6'h20;

  localparam logic [4:0] OP_FADD   = 5'b00000;
  localparam logic [4:0] OP_FSUB   = 5'b00001;
  localparam logic [4:0] OP_FMUL   = 5'b00010;
  localparam logic [4:0] OP_FDIV   = 5'b00011;
  localparam logic [4:0] OP_FSQRT  = 5'b00100;
  localparam logic [4:0] OP_FHALF  = 5'b00101;
  localparam logic [4:0] OP_FINV   = 5'b00110;
  localparam logic [4:0] OP_FFLOOR = 5'b00111;
  localparam logic [4:0] OP_FTOI   = 5'b11000;
  localparam logic [4:0] OP_ITOF   = 5'b11001;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [IDX_W-1:0] rd;
  } slot_t;

  slot_t             slot_q [1:MAX_LAT];
  slot_t             slot_d [1:MAX_LAT];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [LAT_W-1:0]  lat_c;
  logic              raw_c;
  logic              waw_c;
  logic              clash_c;

  // Latency lookup for the op on the request bus
  always_comb begin
    lat_c = LAT_W'(1);
    if (!funct5[4] && (funct3 != 3'd0)) begin
      lat_c = LAT_W'(7);
    end else begin
      case (funct5)
        OP_FADD, OP_FSUB:           lat_c = LAT_W'(5);
        OP_FMUL:                    lat_c = LAT_W'(2);
        OP_FDIV:                    lat_c = LAT_W'(11);
        OP_FSQRT, OP_FINV,
        OP_FFLOOR:                  lat_c = LAT_W'(8);
        OP_FHALF, OP_FTOI:          lat_c = LAT_W'(2);
        OP_ITOF:                    lat_c = LAT_W'(4);
        default:                    lat_c = LAT_W'(1);
      endcase
    end
  end

  // Hazard detection: RAW/WAW on the scoreboard (x0 never hazards), structural on the slot
  // that will sit at position L after this cycle's shift, i.e. the one now at L+1
  always_comb begin
    raw_c   = (rs_v[0] && (rs1_idx != X0_IDX) && busy_q[rs1_idx]) ||
              (rs_v[1] && (rs2_idx != X0_IDX) && busy_q[rs2_idx]) ||
              (rs_v[2] && (rs3_idx != X0_IDX) && busy_q[rs3_idx]);
    waw_c   = rd_we && (rd_idx != X0_IDX) && busy_q[rd_idx];
    clash_c = 1'b0;
    for (int unsigned k = 1; k < MAX_LAT; k++) begin
      if (lat_c == LAT_W'(k)) clash_c = slot_q[k+1].v;
    end
  end

  assign req_ready   = req_valid && !(raw_c || waw_c || clash_c);
  assign issue_valid = req_valid && req_ready;
  assign issue_lat   = issue_valid ? lat_c : '0;

  assign wb_valid = slot_q[1].v;
  assign wb_we    = slot_q[1].we;
  assign wb_rd    = slot_q[1].rd;

  // Any reserved writeback slot
  always_comb begin
    inflight = 1'b0;
    for (int unsigned k = 1; k <= MAX_LAT; k++) begin
      inflight = inflight | slot_q[k].v;
    end
  end

  // Next slot and busy state: shift, reserve on issue, clear busy on register writeback
  always_comb begin
    for (int unsigned k = 1; k < MAX_LAT; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MAX_LAT] = '0;
    if (issue_valid) begin
      for (int unsigned k = 1; k <= MAX_LAT; k++) begin
        if (lat_c == LAT_W'(k)) begin
          slot_d[k].v  = 1'b1;
          slot_d[k].we = rd_we;
          slot_d[k].rd = rd_idx;
        end
      end
    end
    busy_d = busy_q;
    if (slot_q[1].v && slot_q[1].we) busy_d[slot_q[1].rd] = 1'b0;
    if (issue_valid && rd_we && (rd_idx != X0_IDX)) busy_d[rd_idx] = 1'b1;
  end

  // State registers; reset drops every reservation and in-flight result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 1; k <= MAX_LAT; k++) begin
        slot_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      slot_q <= slot_d;
      busy_q <= busy_d;
    end
  end

`ifdef FPU_SCHED_PERF_EN
  // Issue and stall-cause counters; a stall is charged to its first cause RAW > WAW > slot
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issue    <= '0;
      perf_haz_raw  <= '0;
      perf_haz_waw  <= '0;
      perf_haz_slot <= '0;
    end else begin
      if (issue_valid) perf_issue <= perf_issue + 32'd1;
      if (req_valid && !req_ready) begin
        if (raw_c)        perf_haz_raw  <= perf_haz_raw + 32'd1;
        else if (waw_c)   perf_haz_waw  <= perf_haz_waw + 32'd1;
        else if (clash_c) perf_haz_slot <= perf_haz_slot + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched with a writeback scoreboard ordered by due cycle.
module tb_fpu_issue_sched;

  localparam logic [4:0] F_ADD   = 5'b00000;
  localparam logic [4:0] F_SUB   = 5'b00001;
  localparam logic [4:0] F_MUL   = 5'b00010;
  localparam logic [4:0] F_DIV   = 5'b00011;
  localparam logic [4:0] F_SQRT  = 5'b00100;
  localparam logic [4:0] F_HALF  = 5'b00101;
  localparam logic [4:0] F_INV   = 5'b00110;
  localparam logic [4:0] F_FLOOR = 5'b00111;
  localparam logic [4:0] F_SGNJ  = 5'b01000;
  localparam logic [4:0] F_COMP  = 5'b10100;
  localparam logic [4:0] F_TOI   = 5'b11000;
  localparam logic [4:0] F_ITOF  = 5'b11001;
  localparam logic [4:0] F_UNL   = 5'b01111;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] funct5;
  logic [2:0] funct3;
  logic [2:0] rs_v;
  logic [5:0] rs1_idx, rs2_idx, rs3_idx;
  logic       rd_we;
  logic [5:0] rd_idx;
  logic       issue_valid;
  logic [3:0] issue_lat;
  logic       wb_valid, wb_we;
  logic [5:0] wb_rd;
  logic       inflight;
`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_haz_raw, perf_haz_waw, perf_haz_slot;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         due;
    logic [5:0] rd;
    logic       we;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issue_sched dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .funct5(funct5), .funct3(funct3), .rs_v(rs_v),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs3_idx(rs3_idx),
    .rd_we(rd_we), .rd_idx(rd_idx),
    .issue_valid(issue_valid), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .inflight(inflight)
`ifdef FPU_SCHED_PERF_EN
    , .perf_issue(perf_issue), .perf_haz_raw(perf_haz_raw),
    .perf_haz_waw(perf_haz_waw), .perf_haz_slot(perf_haz_slot)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference latency table
  function automatic int model_lat(input logic [4:0] f5, input logic [2:0] f3);
    if (f5[4] == 1'b0 && f3 != 3'd0) return 7;
    case (f5)
      F_ADD, F_SUB:           return 5;
      F_MUL, F_HALF, F_TOI:   return 2;
      F_DIV:                  return 11;
      F_SQRT, F_INV, F_FLOOR: return 8;
      F_ITOF:                 return 4;
      default:                return 1;
    endcase
  endfunction

  task automatic push(input int due, input logic [5:0] rd, input logic we);
    exp_t e;
    int pos;
    e.due = due; e.rd = rd; e.we = we;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > due) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // One cycle presenting an op; checks ready and, when accepted, latency and expected writeback
  task automatic op(input logic [4:0] f5, input logic [2:0] f3, input logic [2:0] rsv,
                    input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] r3,
                    input logic we, input logic [5:0] rd, input bit exp_rdy, input string tag);
    @(posedge clk); #1;
    req_valid = 1'b1; funct5 = f5; funct3 = f3; rs_v = rsv;
    rs1_idx = r1; rs2_idx = r2; rs3_idx = r3; rd_we = we; rd_idx = rd;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, "_issue"}, 32'(issue_valid), 32'(exp_rdy));
    if (exp_rdy) begin
      chk({tag, "_lat"}, 32'(issue_lat), 32'(model_lat(f5, f3)));
      push(cyc + model_lat(f5, f3), rd, we);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = 1'b0; rs_v = 3'b000; rd_we = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !inflight) break;
      idle(1);
    end
    chk({tag, "_drain"}, 32'(sb.size() == 0 && inflight == 1'b0), 32'd1);
  endtask

  // Writeback monitor against the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_cycle", cyc, e.due);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_we", 32'(wb_we), 32'(e.we));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("wb_missing", 32'(wb_valid), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FPU_SCHED_PERF_EN
    int raw0, iss0;
`endif
    rstn = 1'b0; req_valid = 1'b0; funct5 = '0; funct3 = '0; rs_v = '0;
    rs1_idx = '0; rs2_idx = '0; rs3_idx = '0; rd_we = 1'b0; rd_idx = '0;

    // Reset state; req_ready follows req_valid
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b1;
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rstn = 1'b1; mon_en = 1'b1;
    @(negedge clk);

    // 1: FADD f3 at t0, wb at t5; no bypass at t5, source free at t6
    op(F_ADD, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd3, 1'b1, "t1_fadd");
    idle(4);
    op(F_ADD, 3'd0, 3'b001, 6'd3, 6'd0, 6'd0, 1'b1, 6'd13, 1'b0, "t1_raw_t5");
    op(F_ADD, 3'd0, 3'b001, 6'd3, 6'd0, 6'd0, 1'b1, 6'd13, 1'b1, "t1_ok_t6");
    chk("t1_inflight_t6", 32'(inflight), 32'd0);
    drain("t1");

`ifdef FPU_SCHED_PERF_EN
    raw0 = int'(perf_haz_raw); iss0 = int'(perf_issue);
`endif
    // 2: FMUL f4 then dependent FADD f5 stalls two cycles
    op(F_MUL, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd4, 1'b1, "t2_fmul");
    op(F_ADD, 3'd0, 3'b001, 6'd4, 6'd0, 6'd0, 1'b1, 6'd5, 1'b0, "t2_raw_t1");
    op(F_ADD, 3'd0, 3'b001, 6'd4, 6'd0, 6'd0, 1'b1, 6'd5, 1'b0, "t2_raw_t2");
    op(F_ADD, 3'd0, 3'b001, 6'd4, 6'd0, 6'd0, 1'b1, 6'd5, 1'b1, "t2_ok_t3");
    drain("t2");
`ifdef FPU_SCHED_PERF_EN
    chk("t2_perf_raw", perf_haz_raw - 32'(raw0), 32'd2);
    chk("t2_perf_issue", perf_issue - 32'(iss0), 32'd2);
`endif

    // 3: FDIV holds slot 11; FMUL at t9 would also land at t11
    op(F_DIV, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd6, 1'b1, "t3_fdiv");
    idle(8);
    op(F_MUL, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd7, 1'b0, "t3_slot_t9");
    op(F_MUL, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd7, 1'b1, "t3_ok_t10");
    drain("t3");

    // 4a: back-to-back independent ops
    op(F_SGNJ, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd8, 1'b1, "t4_sgnj");
    op(F_ADD, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd9, 1'b1, "t4_fadd");
    drain("t4a");

    // 4b: WAW on f8 holds FMUL until t6
    op(F_SUB, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd8, 1'b1, "t4_fsub");
    for (int i = 1; i <= 5; i++) begin
      op(F_MUL, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd8, 1'b0, $sformatf("t4_waw_t%0d", i));
    end
    op(F_MUL, 3'd0, 3'b011, 6'd1, 6'd2, 6'd0, 1'b1, 6'd8, 1'b1, "t4_waw_ok_t6");
    drain("t4b");

    // 5: x0 never busy as source or destination; fused op latency
    op(F_TOI, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'h20, 1'b1, "t5_ftoi_x0");
    op(F_ITOF, 3'd0, 3'b001, 6'h20, 6'd0, 6'd0, 1'b1, 6'd12, 1'b1, "t5_itof_src_x0");
    op(F_TOI, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'h20, 1'b1, "t5_ftoi_x0_again");
    drain("t5a");
    op(F_ADD, 3'b001, 3'b111, 6'd1, 6'd2, 6'd3, 1'b1, 6'd10, 1'b1, "t5_fused");
    drain("t5b");

    // 6: reset mid-flight drops FSQRT f11
    op(F_SQRT, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'd11, 1'b1, "t6_fsqrt");
    idle(2);
    @(posedge clk); #1;
    rstn = 1'b0; req_valid = 1'b0; rs_v = 3'b000; rd_we = 1'b0;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_inflight_after_rst", 32'(inflight), 32'd0);
    chk("t6_wb_after_rst", 32'(wb_valid), 32'd0);
    idle(4);
    op(F_ADD, 3'd0, 3'b001, 6'd11, 6'd0, 6'd0, 1'b1, 6'd11, 1'b1, "t6_f11_free");
    drain("t6");

    // Remaining latency table entries, one at a time
    op(F_HALF, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'd16, 1'b1, "lat_fhalf");
    drain("lat_fhalf");
    op(F_INV, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'd17, 1'b1, "lat_finv");
    drain("lat_finv");
    op(F_FLOOR, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'd18, 1'b1, "lat_ffloor");
    drain("lat_ffloor");
    op(F_COMP, 3'b010, 3'b011, 6'd1, 6'd2, 6'd0, 1'b0, 6'h25, 1'b1, "lat_fcomp");
    op(F_ADD, 3'd0, 3'b001, 6'h25, 6'd0, 6'd0, 1'b1, 6'd19, 1'b1, "nowe_not_busy");
    drain("lat_fcomp");
    op(F_UNL, 3'd0, 3'b001, 6'd1, 6'd0, 6'd0, 1'b1, 6'd20, 1'b1, "lat_unlisted");
    drain("lat_unlisted");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
